// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word sizes, block-level state encoding and the
// small sigma functions used by the message schedule and its checkers.
package sha256_pkg;

   localparam int WORD_W      = 32;
   localparam int ROUNDS      = 64;
   localparam int BLOCK_WORDS = 16;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      GEN  = 2'd2,
      FIN  = 2'd3
   } state_t;

   function automatic word_t rotr(input word_t x, input int unsigned n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

   function automatic word_t sigma0(input word_t x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic word_t sigma1(input word_t x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

endpackage

// File: rtl/w_sigma.sv
// Next-schedule-word datapath: W[t+16] from the four window taps it depends on.
module w_sigma
   import sha256_pkg::*;
(
   input  logic [WORD_W-1:0] w0,
   input  logic [WORD_W-1:0] w1,
   input  logic [WORD_W-1:0] w9,
   input  logic [WORD_W-1:0] w14,
   output logic [WORD_W-1:0] w_next
);

   // Carries out of bit 31 fall off naturally: the sum is modulo 2^32.
   assign w_next = sigma1(w14) + w9 + sigma0(w1) + w0;

endmodule

// File: rtl/w_schedule.sv
// SHA-256 message schedule: loads one 16-word block from message memory, then
// streams W[0..63] to the compression stage under a valid/ready handshake.
module w_schedule
   import sha256_pkg::*;
#(
   parameter logic [5:0] MSG_BASE = 6'd0,
   parameter int         WORDS    = ROUNDS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              msg_rd,
   output logic [5:0]        msg_addr,
   input  logic [WORD_W-1:0] msg_data,
   output logic              w_valid,
   input  logic              w_ready,
   output logic [WORD_W-1:0] w_data,
   output logic [5:0]        w_index,
   output logic              done
);

   localparam logic [5:0] LAST_T    = 6'(WORDS - 1);
   localparam logic [4:0] LOAD_LAST = 5'(BLOCK_WORDS);

   state_t            state;
   logic [4:0]        k;
   logic [5:0]        t;
   logic [WORD_W-1:0] win [BLOCK_WORDS];
   logic [WORD_W-1:0] w_next;

   w_sigma u_sigma (
      .w0     (win[0]),
      .w1     (win[1]),
      .w9     (win[9]),
      .w14    (win[14]),
      .w_next (w_next)
   );

   // NOTE: sequential state uses non-blocking assignments only, and the window
   // is explicitly cleared on reset because its contents are observable on w_data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         k     <= '0;
         t     <= '0;
         for (int i = 0; i < BLOCK_WORDS; i++) win[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= LOAD;
                  k     <= '0;
                  t     <= '0;
               end
            end
            LOAD: begin
               // Read data trails the strobe by one cycle; shifting it in from
               // the top leaves word 0 in win[0] after the 16th capture.
               if (k != 5'd0) begin
                  for (int i = 0; i < BLOCK_WORDS - 1; i++) win[i] <= win[i+1];
                  win[BLOCK_WORDS-1] <= msg_data;
               end
               if (k == LOAD_LAST) state <= GEN;
               else                k     <= k + 5'd1;
            end
            GEN: begin
               if (w_ready) begin
                  for (int i = 0; i < BLOCK_WORDS - 1; i++) win[i] <= win[i+1];
                  win[BLOCK_WORDS-1] <= w_next;
                  t                  <= t + 6'd1;
                  if (t == LAST_T) state <= FIN;
               end
            end
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: every output gets a value on every path, so no latch can be inferred.
   always_comb begin
      msg_rd   = (state == LOAD) && (k < LOAD_LAST);
      msg_addr = msg_rd ? MSG_BASE + {2'b00, k[3:0]} : 6'd0;
      w_valid  = (state == GEN);
      w_data   = w_valid ? win[0] : '0;
      w_index  = w_valid ? t : 6'd0;
      done     = (state == FIN);
   end

endmodule

// File: tb/tb_w_schedule.sv
// Self-checking bench for w_schedule: directed block runs plus random blocks,
// compared against an independent schedule model through a scoreboard queue.
module tb_w_schedule;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        w_ready = 1'b1;
   logic        msg_rd;
   logic [5:0]  msg_addr;
   logic [31:0] msg_data = '0;
   logic        w_valid;
   logic [31:0] w_data;
   logic [5:0]  w_index;
   logic        done;

   logic        start56 = 1'b0;
   logic        ready56 = 1'b1;
   logic        rd56;
   logic [5:0]  addr56;
   logic [31:0] data56 = '0;
   logic        valid56;
   logic [31:0] wdata56;
   logic [5:0]  idx56;
   logic        done56;

   logic [31:0] mem [64];
   logic [31:0] exp_w [64];
   logic [37:0] sb [$];
   int          checks = 0;
   int          errors = 0;

   w_schedule dut (
      .clk(clk), .reset(reset), .start(start),
      .msg_rd(msg_rd), .msg_addr(msg_addr), .msg_data(msg_data),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .w_index(w_index), .done(done)
   );

   w_schedule #(.MSG_BASE(6'd56)) dut56 (
      .clk(clk), .reset(reset), .start(start56),
      .msg_rd(rd56), .msg_addr(addr56), .msg_data(data56),
      .w_valid(valid56), .w_ready(ready56), .w_data(wdata56),
      .w_index(idx56), .done(done56)
   );

   always #5 clk = ~clk;

   // Message memory with one cycle of read latency.
   always @(posedge clk) begin
      if (msg_rd) msg_data <= mem[msg_addr];
      if (rd56)   data56   <= mem[addr56];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x} >> n;
      return d[31:0];
   endfunction

   function automatic logic [31:0] ref_s0(input logic [31:0] x);
      return ror(x, 7) ^ ror(x, 18) ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] ref_s1(input logic [31:0] x);
      return ror(x, 17) ^ ror(x, 19) ^ {10'b0, x[31:10]};
   endfunction

   task automatic build_exp(input int base);
      for (int i = 0; i < 16; i++) exp_w[i] = mem[(base + i) % 64];
      for (int i = 16; i < 64; i++)
         exp_w[i] = ref_s1(exp_w[i-2]) + exp_w[i-7] + ref_s0(exp_w[i-15]) + exp_w[i-16];
   endtask

   task automatic push_exp();
      for (int i = 0; i < 64; i++) sb.push_back({6'(i), exp_w[i]});
   endtask

   // mode: 0 ready high, 1 directed stalls, 2 random stalls, 3 reset at t=30.
   // exp_first < 0 means done is expected at 82 plus the stall cycles seen.
   task automatic run_block(input int mode, input int ndone, input int exp_first, input int budget);
      int          n, dones, stalls, s5, s40;
      bit          prev_stall, prev_done, aborted;
      logic [31:0] pdata;
      logic [5:0]  pidx;
      logic [37:0] e;
      n = 0; dones = 0; stalls = 0; s5 = 0; s40 = 0;
      prev_stall = 1'b0; prev_done = 1'b0; aborted = 1'b0;
      pdata = '0; pidx = '0;
      @(negedge clk);
      reset = 1'b1; start = 1'b1; w_ready = 1'b1;
      @(posedge clk);
      while (dones < ndone && n < budget && !aborted) begin
         @(negedge clk);
         n++;
         if (ndone == 1) start = 1'b0;
         if (prev_stall) begin
            check("stall_valid", 32'(w_valid), 32'd1);
            check("stall_index", 32'(w_index), 32'(pidx));
            check("stall_data", w_data, pdata);
         end
         if (prev_done) check("done_pulse", 32'(done), 32'd0);
         if (mode == 3 && w_valid && w_index == 6'd30) begin
            reset = 1'b0;
            #1;
            check("rst_valid", 32'(w_valid), 32'd0);
            check("rst_data", w_data, 32'd0);
            check("rst_index", 32'(w_index), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_rd", 32'(msg_rd), 32'd0);
            aborted = 1'b1;
         end else begin
            case (mode)
               1: begin
                  if (w_valid && w_index == 6'd5 && s5 < 3) begin
                     w_ready = 1'b0; s5++;
                  end else if (w_valid && w_index == 6'd40 && s40 < 1) begin
                     w_ready = 1'b0; s40++;
                  end else w_ready = 1'b1;
               end
               2:       w_ready = ($urandom_range(0, 3) != 0);
               default: w_ready = 1'b1;
            endcase
            if (w_valid && w_ready) begin
               check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  check("w_index", 32'(w_index), 32'(e[37:32]));
                  check("w_data", w_data, e[31:0]);
               end
            end
            prev_stall = w_valid && !w_ready;
            if (prev_stall) stalls++;
            pdata = w_data;
            pidx  = w_index;
            prev_done = done;
            if (done) begin
               dones++;
               check("done_cycle", 32'(n),
                     32'(exp_first >= 0 ? exp_first + (dones - 1) * 83 : 82 + stalls));
               if (dones == ndone) start = 1'b0;
            end
         end
      end
      if (mode == 3) check("abort_reached", 32'(aborted), 32'd1);
      else begin
         check("done_count", 32'(dones), 32'(ndone));
         @(negedge clk);
         check("done_end", 32'(done), 32'd0);
         check("sb_drained", 32'(sb.size()), 32'd0);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      mem[0] = 32'h61626380;
      for (int i = 1; i < 15; i++) mem[i] = 32'h0;
      mem[15] = 32'h00000018;

      // Reset state of both instances.
      repeat (2) @(negedge clk);
      check("reset_rd", 32'(msg_rd), 32'd0);
      check("reset_addr", 32'(msg_addr), 32'd0);
      check("reset_valid", 32'(w_valid), 32'd0);
      check("reset_data", w_data, 32'd0);
      check("reset_index", 32'(w_index), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset56_rd", 32'(rd56), 32'd0);
      check("reset56_valid", 32'(valid56), 32'd0);

      // "abc" block, start honoured on the first edge after reset release.
      build_exp(0);
      exp_w[0]  = 32'h61626380;
      exp_w[15] = 32'h00000018;
      exp_w[16] = 32'h61626380;
      exp_w[17] = 32'h000F0000;
      push_exp();
      run_block(0, 1, 82, 200);

      // Handshake stalls at t=5 (3 cycles) and t=40 (1 cycle).
      build_exp(0);
      push_exp();
      run_block(1, 1, 86, 200);

      // Reset mid-GEN, then a clean full block.
      push_exp();
      run_block(3, 1, -1, 200);
      sb.delete();
      push_exp();
      run_block(0, 1, 82, 200);

      // start held high: two blocks back to back on an 83-cycle period.
      push_exp();
      push_exp();
      run_block(0, 2, 82, 400);
      repeat (2) begin
         @(negedge clk);
         check("idle_rd", 32'(msg_rd), 32'd0);
         check("idle_valid", 32'(w_valid), 32'd0);
      end

      // MSG_BASE=56: address wrap and window contents.
      @(negedge clk);
      start56 = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= 83; n++) begin
         @(negedge clk);
         start56 = 1'b0;
         if (n <= 16) begin
            check("b56_rd", 32'(rd56), 32'd1);
            check("b56_addr", 32'(addr56), 32'((56 + n - 1) % 64));
         end
         if (n == 17) check("b56_rd_end", 32'(rd56), 32'd0);
         if (n >= 18 && n <= 33) begin
            check("b56_valid", 32'(valid56), 32'd1);
            check("b56_index", 32'(idx56), 32'(n - 18));
            check("b56_w", wdata56, mem[(56 + n - 18) % 64]);
         end
         if (n == 81 || n == 83) check("b56_done_low", 32'(done56), 32'd0);
         if (n == 82) check("b56_done", 32'(done56), 32'd1);
      end

      // Random blocks with random stalls.
      for (int b = 0; b < 200; b++) begin
         for (int i = 0; i < 16; i++) mem[i] = $urandom;
         build_exp(0);
         push_exp();
         run_block(2, 1, -1, 400);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
